// File: rtl/regbank_ctrl.sv
// Operand sequencing controller for the 16 x 16-bit register bank: scoreboarded
// hazard stall, single-cycle bank strobes, and writeback arbitration onto the write port.
module regbank_ctrl #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [AW-1:0]      req_ra,
  input  logic [AW-1:0]      req_rb,
  input  logic [AW-1:0]      req_rd,
  input  logic               req_use_a,
  input  logic               req_use_b,
  input  logic               req_use_d,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_a,
  output logic [DW-1:0]      rsp_b,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [AW-1:0]      wb_addr,
  input  logic [DW-1:0]      wb_data,
  output logic [AW-1:0]      bank_a_addr,
  output logic [AW-1:0]      bank_b_addr,
  output logic [AW-1:0]      bank_wr_addr,
  output logic               bank_a_read,
  output logic               bank_b_read,
  output logic               bank_write,
  output logic [DW-1:0]      bank_wr_data,
  input  logic [DW-1:0]      bank_a_data,
  input  logic [DW-1:0]      bank_b_data,
  output logic [(1<<AW)-1:0] busy,
  output logic               spurious_wb
);

  localparam int unsigned NR = 1 << AW;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    READ   = 3'd2,
    SETTLE = 3'd3,
    RESP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic            use_a_q, use_a_d, use_b_q, use_b_d, use_d_q, use_d_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            spurious_q, spurious_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
  logic [AW-1:0]   bank_a_addr_q, bank_a_addr_d, bank_b_addr_q, bank_b_addr_d;
  logic            bank_a_read_q, bank_a_read_d, bank_b_read_q, bank_b_read_d;
  logic            bank_write_q, bank_write_d;
  logic [AW-1:0]   bank_wr_addr_q, bank_wr_addr_d;
  logic [DW-1:0]   bank_wr_data_q, bank_wr_data_d;

  logic            req_fire_c;
  logic            wb_fire_c;
  logic            hazard_c;
  logic [NR-1:0]   busy_set_c;
  logic [NR-1:0]   busy_clr_c;

  // Handshake readiness follows registered state, forced low while reset is held.
  assign req_ready  = (state_q == IDLE) & ~RST;
  assign wb_ready   = ~bank_write_q & ~RST;
  assign req_fire_c = req_valid & req_ready;
  assign wb_fire_c  = wb_valid & wb_ready;

  assign hazard_c = (use_a_q & busy_q[ra_q]) |
                    (use_b_q & busy_q[rb_q]) |
                    (use_d_q & busy_q[rd_q]);

  always_comb begin
    state_d        = state_q;
    ra_d           = ra_q;
    rb_d           = rb_q;
    rd_d           = rd_q;
    use_a_d        = use_a_q;
    use_b_d        = use_b_q;
    use_d_d        = use_d_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_a_d        = rsp_a_q;
    rsp_b_d        = rsp_b_q;
    bank_a_addr_d  = bank_a_addr_q;
    bank_b_addr_d  = bank_b_addr_q;
    bank_a_read_d  = 1'b0;
    bank_b_read_d  = 1'b0;
    bank_write_d   = wb_fire_c;
    bank_wr_addr_d = bank_wr_addr_q;
    bank_wr_data_d = bank_wr_data_q;
    busy_set_c     = '0;
    busy_clr_c     = '0;
    spurious_d     = spurious_q;

    // Writeback always wins the write port; the strobe itself blocks the next accept.
    if (wb_fire_c) begin
      bank_wr_addr_d = wb_addr;
      bank_wr_data_d = wb_data;
      busy_clr_c     = NR'(1) << wb_addr;
      if (!busy_q[wb_addr]) begin
        spurious_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (req_fire_c) begin
          ra_d    = req_ra;
          rb_d    = req_rb;
          rd_d    = req_rd;
          use_a_d = req_use_a;
          use_b_d = req_use_b;
          use_d_d = req_use_d;
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Holding here during a wb accept keeps READ out of the bank_write cycle.
        if (!hazard_c && !wb_fire_c) begin
          if (use_d_q) begin
            busy_set_c = NR'(1) << rd_q;
          end
          if (use_a_q || use_b_q) begin
            bank_a_read_d = use_a_q;
            bank_b_read_d = use_b_q;
            bank_a_addr_d = ra_q;
            bank_b_addr_d = rb_q;
            state_d       = READ;
          end else begin
            // No operands: SETTLE captures nothing, giving a two-edge response.
            state_d = SETTLE;
          end
        end
      end
      READ: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (use_a_q) begin
          rsp_a_d = bank_a_data;
        end
        if (use_b_q) begin
          rsp_b_d = bank_b_data;
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A forced same-bit set and clear resolves in favour of the set.
    busy_d = (busy_q & ~busy_clr_c) | busy_set_c;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      ra_q           <= '0;
      rb_q           <= '0;
      rd_q           <= '0;
      use_a_q        <= 1'b0;
      use_b_q        <= 1'b0;
      use_d_q        <= 1'b0;
      busy_q         <= '0;
      spurious_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_a_q        <= '0;
      rsp_b_q        <= '0;
      bank_a_addr_q  <= '0;
      bank_b_addr_q  <= '0;
      bank_a_read_q  <= 1'b0;
      bank_b_read_q  <= 1'b0;
      bank_write_q   <= 1'b0;
      bank_wr_addr_q <= '0;
      bank_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      ra_q           <= ra_d;
      rb_q           <= rb_d;
      rd_q           <= rd_d;
      use_a_q        <= use_a_d;
      use_b_q        <= use_b_d;
      use_d_q        <= use_d_d;
      busy_q         <= busy_d;
      spurious_q     <= spurious_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_a_q        <= rsp_a_d;
      rsp_b_q        <= rsp_b_d;
      bank_a_addr_q  <= bank_a_addr_d;
      bank_b_addr_q  <= bank_b_addr_d;
      bank_a_read_q  <= bank_a_read_d;
      bank_b_read_q  <= bank_b_read_d;
      bank_write_q   <= bank_write_d;
      bank_wr_addr_q <= bank_wr_addr_d;
      bank_wr_data_q <= bank_wr_data_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_a        = rsp_a_q;
  assign rsp_b        = rsp_b_q;
  assign bank_a_addr  = bank_a_addr_q;
  assign bank_b_addr  = bank_b_addr_q;
  assign bank_wr_addr = bank_wr_addr_q;
  assign bank_a_read  = bank_a_read_q;
  assign bank_b_read  = bank_b_read_q;
  assign bank_write   = bank_write_q;
  assign bank_wr_data = bank_wr_data_q;
  assign busy         = busy_q;
  assign spurious_wb  = spurious_q;

endmodule

// File: tb/tb_regbank_ctrl.sv
// Directed bench for regbank_ctrl: register bank model, vector table for operand
// fetches, and hand-written sequences for stalls, writeback pacing and reset.
module tb_regbank_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_ra, req_rb, req_rd;
  logic          req_use_a, req_use_b, req_use_d;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_a, rsp_b;
  logic          wb_valid, wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] bank_a_addr, bank_b_addr, bank_wr_addr;
  logic          bank_a_read, bank_b_read, bank_write;
  logic [DW-1:0] bank_wr_data;
  logic [DW-1:0] bank_a_data = '0;
  logic [DW-1:0] bank_b_data = '0;
  logic [NR-1:0] busy;
  logic          spurious_wb;

  logic [DW-1:0] mem [NR];
  logic          mem_init = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  regbank_ctrl #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
    .req_use_a(req_use_a), .req_use_b(req_use_b), .req_use_d(req_use_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a), .rsp_b(rsp_b),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .bank_a_addr(bank_a_addr), .bank_b_addr(bank_b_addr), .bank_wr_addr(bank_wr_addr),
    .bank_a_read(bank_a_read), .bank_b_read(bank_b_read), .bank_write(bank_write),
    .bank_wr_data(bank_wr_data), .bank_a_data(bank_a_data), .bank_b_data(bank_b_data),
    .busy(busy), .spurious_wb(spurious_wb)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read bank: preloaded on the first edge, then driven by the strobes.
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < NR; i++) mem[i] <= 16'(16'h1111 * i);
      mem[3]   <= 16'h1234;
      mem[5]   <= 16'hBEEF;
      mem_init <= 1'b1;
    end else begin
      if (bank_write)  mem[bank_wr_addr] <= bank_wr_data;
      if (bank_a_read) bank_a_data <= mem[bank_a_addr];
      if (bank_b_read) bank_b_data <= mem[bank_b_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_req(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                          input logic ua, input logic ub, input logic ud);
    req_ra = ra; req_rb = rb; req_rd = rd;
    req_use_a = ua; req_use_b = ub; req_use_d = ud;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) step();
    chk("req_ready_wait", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    for (int i = 0; i < max && !rsp_valid; i++) step();
    chk("rsp_valid_wait", 32'(rsp_valid), 32'd1);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic do_wb(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wb_addr = addr; wb_data = data; wb_valid = 1'b1;
    for (int i = 0; i < 4 && !wb_ready; i++) step();
    chk("wb_ready_wait", 32'(wb_ready), 32'd1);
    step();
    wb_valid = 1'b0;
    chk("wb_strobe", 32'(bank_write), 32'd1);
    step();
  endtask

  typedef struct {
    logic [AW-1:0] ra, rb, rd;
    logic          ua, ub, ud;
    logic [DW-1:0] ea, eb;
    logic [NR-1:0] ebusy;
    logic [DW-1:0] wbd;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{ra:4'd1,  rb:4'd2, rd:4'd0,  ua:1, ub:1, ud:0, ea:16'h1111, eb:16'h2222, ebusy:16'h0000, wbd:16'h0000};
    vt[1] = '{ra:4'd15, rb:4'd0, rd:4'd0,  ua:1, ub:1, ud:0, ea:16'hFFFF, eb:16'h0000, ebusy:16'h0000, wbd:16'h0000};
    vt[2] = '{ra:4'd4,  rb:4'd6, rd:4'd0,  ua:1, ub:0, ud:0, ea:16'h4444, eb:16'h0000, ebusy:16'h0000, wbd:16'h0000};
    vt[3] = '{ra:4'd0,  rb:4'd3, rd:4'd0,  ua:0, ub:1, ud:0, ea:16'h4444, eb:16'h1234, ebusy:16'h0000, wbd:16'h0000};
    vt[4] = '{ra:4'd5,  rb:4'd5, rd:4'd12, ua:1, ub:1, ud:1, ea:16'hBEEF, eb:16'hBEEF, ebusy:16'h1000, wbd:16'hC0DE};
    vt[5] = '{ra:4'd7,  rb:4'd8, rd:4'd15, ua:1, ub:1, ud:1, ea:16'h00AA, eb:16'h8888, ebusy:16'h8000, wbd:16'hF00D};
    vt[6] = '{ra:4'd0,  rb:4'd0, rd:4'd10, ua:0, ub:0, ud:1, ea:16'h00AA, eb:16'h8888, ebusy:16'h0400, wbd:16'h0A0A};

    RST = 1'b1;
    req_valid = 1'b0; req_ra = '0; req_rb = '0; req_rd = '0;
    req_use_a = 1'b0; req_use_b = 1'b0; req_use_d = 1'b0;
    rsp_ready = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({bank_a_read, bank_b_read, bank_write}), 32'd0);
    chk("rst_spurious", 32'(spurious_wb), 32'd0);
    RST = 1'b0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Basic fetch: R3/R5 sources, R7 destination, exact strobe and response timing
    send_req(4'd3, 4'd5, 4'd7, 1'b1, 1'b1, 1'b1);
    chk("e0_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("e0_a_read", 32'(bank_a_read), 32'd0);
    step();
    chk("e1_reads", 32'({bank_a_read, bank_b_read}), 32'd3);
    chk("e1_a_addr", 32'(bank_a_addr), 32'd3);
    chk("e1_b_addr", 32'(bank_b_addr), 32'd5);
    chk("e1_busy", 32'(busy), 32'h0080);
    step();
    chk("e2_reads", 32'({bank_a_read, bank_b_read}), 32'd0);
    chk("e2_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("e3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("e3_rsp_a", 32'(rsp_a), 32'h1234);
    chk("e3_rsp_b", 32'(rsp_b), 32'hBEEF);
    accept_rsp();

    // RAW stall on R7, released by writeback; then a held-off response
    send_req(4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("raw_no_read", 32'(bank_a_read), 32'd0);
      chk("raw_no_rsp", 32'(rsp_valid), 32'd0);
    end
    wb_addr = 4'd7; wb_data = 16'h00AA; wb_valid = 1'b1;
    chk("raw_wb_ready", 32'(wb_ready), 32'd1);
    step();
    wb_valid = 1'b0;
    chk("raw_wb_strobe", 32'(bank_write), 32'd1);
    chk("raw_wb_ready_low", 32'(wb_ready), 32'd0);
    chk("raw_busy_clr", 32'(busy), 32'd0);
    chk("raw_read_held", 32'(bank_a_read), 32'd0);
    step();
    chk("raw_read_after", 32'({bank_a_read, bank_write}), 32'b10);
    wait_rsp(6);
    chk("raw_rsp_a", 32'(rsp_a), 32'h00AA);
    chk("raw_rsp_b_hold", 32'(rsp_b), 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_a", 32'(rsp_a), 32'h00AA);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    accept_rsp();

    // Table of operand fetches; destinations are released by writeback afterwards
    for (int v = 0; v < 7; v++) begin
      send_req(vt[v].ra, vt[v].rb, vt[v].rd, vt[v].ua, vt[v].ub, vt[v].ud);
      wait_rsp(8);
      chk($sformatf("vec%0d_rsp_a", v), 32'(rsp_a), 32'(vt[v].ea));
      chk($sformatf("vec%0d_rsp_b", v), 32'(rsp_b), 32'(vt[v].eb));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vt[v].ebusy));
      accept_rsp();
      if (vt[v].ud) begin
        do_wb(vt[v].rd, vt[v].wbd);
        chk($sformatf("vec%0d_busy_clr", v), 32'(busy), 32'd0);
        chk($sformatf("vec%0d_mem", v), 32'(mem[vt[v].rd]), 32'(vt[v].wbd));
      end
    end
    chk("vec_spurious", 32'(spurious_wb), 32'd0);

    // Destination-only requests: response two edges after handshake
    send_req(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    step();
    chk("nosrc_e1_valid", 32'(rsp_valid), 32'd0);
    chk("nosrc_e1_reads", 32'({bank_a_read, bank_b_read}), 32'd0);
    step();
    chk("nosrc_e2_valid", 32'(rsp_valid), 32'd1);
    accept_rsp();
    send_req(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b1);
    wait_rsp(6);
    accept_rsp();
    chk("b2b_busy_pre", 32'(busy), 32'h0006);

    // Back-to-back writebacks to R1 and R2: accept, gap, accept
    wb_addr = 4'd1; wb_data = 16'hA001; wb_valid = 1'b1;
    chk("b2b_ready0", 32'(wb_ready), 32'd1);
    step();
    chk("b2b_write0", 32'(bank_write), 32'd1);
    chk("b2b_addr0", 32'(bank_wr_addr), 32'd1);
    chk("b2b_ready1", 32'(wb_ready), 32'd0);
    wb_addr = 4'd2; wb_data = 16'hA002;
    step();
    chk("b2b_write1", 32'(bank_write), 32'd0);
    chk("b2b_ready2", 32'(wb_ready), 32'd1);
    step();
    wb_valid = 1'b0;
    chk("b2b_write2", 32'(bank_write), 32'd1);
    chk("b2b_addr2", 32'(bank_wr_addr), 32'd2);
    chk("b2b_data2", 32'(bank_wr_data), 32'hA002);
    step();
    chk("b2b_write3", 32'(bank_write), 32'd0);
    chk("b2b_mem1", 32'(mem[1]), 32'hA001);
    chk("b2b_mem2", 32'(mem[2]), 32'hA002);
    chk("b2b_busy", 32'(busy), 32'd0);
    chk("b2b_spurious", 32'(spurious_wb), 32'd0);

    // Writeback to a register with no pending write
    do_wb(4'd9, 16'h0909);
    chk("spur_mem9", 32'(mem[9]), 32'h0909);
    chk("spur_flag", 32'(spurious_wb), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("spur_sticky", 32'(spurious_wb), 32'd1);

    // Reset asserted while the read strobes are high
    send_req(4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1);
    step();
    chk("mid_read_strobe", 32'(bank_a_read), 32'd1);
    chk("mid_busy", 32'(busy), 32'h0008);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_strobes", 32'({bank_a_read, bank_b_read, bank_write}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    chk("mid_rst_spur", 32'(spurious_wb), 32'd0);
    chk("mid_rst_ready", 32'({req_ready, wb_ready}), 32'd0);
    step(); step();
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    send_req(4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 1'b0);
    wait_rsp(8);
    chk("post_rst_a", 32'(rsp_a), 32'hA001);
    chk("post_rst_b", 32'(rsp_b), 32'hA002);
    chk("post_rst_busy", 32'(busy), 32'd0);
    accept_rsp();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
